// File: rtl/delay_pkg.sv
// Shared width helpers and ring-buffer index arithmetic for the programmable delay line.
package delay_pkg;

  function automatic int unsigned ptr_w(input int unsigned max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

  function automatic int unsigned dly_w(input int unsigned max);
    return $clog2(max + 1);
  endfunction

  // Explicit wrap: depth need not be a power of two, so no bit truncation.
  function automatic int unsigned ring_sub(input int unsigned ptr, input int unsigned d,
                                           input int unsigned depth);
    return (ptr >= d) ? ptr - d : ptr + depth - d;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read (distributed RAM style).
module delay_ram #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_delay.sv
// Multi-channel delay line with run-time programmable delay, stall and output-valid tracking.
module prog_delay
  import delay_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned N_CH       = 3,
  parameter int unsigned MAX_CYCLES = 16,
  parameter int unsigned INIT_DELAY = 0,
  localparam int unsigned DW        = dly_w(MAX_CYCLES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic [N_CH*WIDTH-1:0] data_i,
  input  logic [DW-1:0]         delay_i,
  input  logic                  delay_load_i,
  input  logic                  flush_i,
  output logic [N_CH*WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic [DW-1:0]         delay_o,
  output logic                  delay_err_o
);

  localparam int unsigned W_PTR  = ptr_w(MAX_CYCLES);
  localparam int unsigned DATA_W = N_CH * WIDTH;
  localparam logic [DW-1:0]    MAX_D    = DW'(MAX_CYCLES);
  localparam logic [DW-1:0]    INIT_D   = DW'(INIT_DELAY);
  localparam logic [W_PTR-1:0] LAST_PTR = W_PTR'(MAX_CYCLES - 1);

  logic [W_PTR-1:0]  wptr_q, wptr_d, rd_idx;
  logic [DW-1:0]     fill_q, fill_d, dly_q, dly_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_data;
  int unsigned       rd_int;

  // Read index from registered state only, so a same-cycle write is never seen (read-old).
  always_comb begin
    rd_int = ring_sub(32'(wptr_q), 32'(dly_q), MAX_CYCLES);
    rd_idx = W_PTR'(rd_int);
  end

  always_comb begin
    wptr_d = wptr_q;
    fill_d = fill_q;
    dly_d  = dly_q;
    err_d  = err_q;
    if (ce_i) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + W_PTR'(1);
    if (flush_i) begin
      fill_d = '0;
    end else if (ce_i && (fill_q != MAX_D)) begin
      fill_d = fill_q + DW'(1);
    end
    if (delay_load_i) begin
      if (delay_i > MAX_D) begin
        dly_d = MAX_D;
        err_d = 1'b1;
      end else begin
        dly_d = delay_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      fill_q <= '0;
      dly_q  <= INIT_D;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      dly_q  <= dly_d;
      err_q  <= err_d;
    end
  end

  delay_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_CYCLES),
    .ADDR_W (W_PTR)
  ) u_ram (
    .clk   (clk_i),
    .we    (ce_i & ~rst_i),
    .waddr (wptr_q),
    .wdata (data_i),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  assign data_o      = (dly_q == '0) ? data_i : rd_data;
  assign valid_o     = (dly_q == '0) || (fill_q >= dly_q);
  assign delay_o     = dly_q;
  assign delay_err_o = err_q;

endmodule

// File: tb/tb_prog_delay.sv
// Self-checking bench for prog_delay: vector table, directed corner sequences, random vs queue model.
module tb_prog_delay;

  localparam int WIDTH = 8;
  localparam int N_CH  = 2;
  localparam int MAXC  = 8;
  localparam int INIT  = 3;
  localparam int DW    = 4;
  localparam int DATW  = WIDTH * N_CH;

  logic            clk = 1'b0;
  logic            rst, ce, load, flush;
  logic [DATW-1:0] din;
  logic [DW-1:0]   dly_in;
  logic [DATW-1:0] data_o;
  logic            valid_o;
  logic [DW-1:0]   delay_o;
  logic            delay_err_o;

  always #5 clk = ~clk;

  prog_delay #(
    .WIDTH      (WIDTH),
    .N_CH       (N_CH),
    .MAX_CYCLES (MAXC),
    .INIT_DELAY (INIT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ce_i         (ce),
    .data_i       (din),
    .delay_i      (dly_in),
    .delay_load_i (load),
    .flush_i      (flush),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .delay_o      (delay_o),
    .delay_err_o  (delay_err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: every accepted sample in order, plus fill, delay and sticky error.
  logic [DATW-1:0] hist[$];
  int m_fill, m_d;
  bit m_err;

  typedef struct {
    bit         ce;
    logic [7:0] d;
    bit         ev;
    logic [7:0] eo;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [DATW-1:0] pk(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {b, b};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit ev;
    int exp_data;
    ev = (m_d == 0) || (m_fill >= m_d);
    chk("delay_o", int'(delay_o), m_d);
    chk("delay_err_o", int'(delay_err_o), int'(m_err));
    chk("valid_o", int'(valid_o), int'(ev));
    if (ev) begin
      exp_data = (m_d == 0) ? int'(din) : int'(hist[hist.size() - m_d]);
      chk("data_o", int'(data_o), exp_data);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      hist.delete();
      m_fill = 0;
      m_d    = INIT;
      m_err  = 1'b0;
    end else begin
      if (ce) begin
        hist.push_back(din);
        if (hist.size() > 4 * MAXC) void'(hist.pop_front());
      end
      if (flush) m_fill = 0;
      else if (ce && m_fill < MAXC) m_fill++;
      if (load) begin
        m_d = (int'(dly_in) > MAXC) ? MAXC : int'(dly_in);
        if (int'(dly_in) > MAXC) m_err = 1'b1;
      end
    end
  endtask

  // Inputs change 1 after posedge; outputs compared at negedge.
  task automatic drive(input bit r, input bit c, input bit l, input bit f,
                       input int dv, input logic [DATW-1:0] d);
    rst = r; ce = c; load = l; flush = f; dly_in = DW'(dv); din = d;
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  int ramp;

  initial begin
    // Ramp 1..6, 4-cycle stall with changing data, then resume with 7, 8.
    for (int i = 0; i < 6; i++) tbl[i] = '{1'b1, 8'(i + 1), (i >= 3), 8'(i - 2)};
    for (int i = 6; i < 10; i++) tbl[i] = '{1'b0, 8'(8'hA0 + i), 1'b1, 8'd4};
    tbl[10] = '{1'b1, 8'd7, 1'b1, 8'd4};
    tbl[11] = '{1'b1, 8'd8, 1'b1, 8'd5};

    rst = 1'b1; ce = 1'b0; load = 1'b0; flush = 1'b0; dly_in = '0; din = '0;
    tick();
    tick();

    for (int i = 0; i < 12; i++) begin
      drive(0, tbl[i].ce, 0, 0, 0, pk(int'(tbl[i].d)));
      chk("tbl_valid", int'(valid_o), int'(tbl[i].ev));
      if (tbl[i].ev) chk("tbl_data", int'(data_o), int'(pk(int'(tbl[i].eo))));
      tick();
    end
    ramp = 8;

    for (int i = 0; i < 2; i++) begin
      ramp++; drive(0, 1, 0, 0, 0, pk(ramp)); tick();
    end

    // Load 5: old delay in load cycle, new one immediately after.
    ramp++; drive(0, 1, 1, 0, 5, pk(ramp));
    chk("load_old_d", int'(data_o), int'(pk(ramp - 3))); tick();
    ramp++; drive(0, 1, 0, 0, 0, pk(ramp));
    chk("d5_delay", int'(delay_o), 5);
    chk("d5_valid", int'(valid_o), 1);
    chk("d5_data", int'(data_o), int'(pk(ramp - 5))); tick();

    ramp++; drive(0, 1, 1, 0, 1, pk(ramp)); tick();
    ramp++; drive(0, 1, 0, 0, 0, pk(ramp));
    chk("d1_data", int'(data_o), int'(pk(ramp - 1))); tick();

    // Full depth: read index equals write index, must return the old entry.
    ramp++; drive(0, 1, 1, 0, 8, pk(ramp)); tick();
    ramp++; drive(0, 1, 0, 0, 0, pk(ramp));
    chk("d8_data", int'(data_o), int'(pk(ramp - 8)));
    chk("d8_valid", int'(valid_o), 1); tick();

    ramp++; drive(0, 1, 1, 0, 12, pk(ramp)); tick();
    for (int i = 0; i < 3; i++) begin
      ramp++; drive(0, 1, 0, 0, 0, pk(ramp));
      chk("ovr_delay", int'(delay_o), 8);
      chk("ovr_err", int'(delay_err_o), 1); tick();
    end

    ramp++; drive(0, 1, 1, 0, 0, pk(ramp)); tick();
    drive(0, 0, 0, 0, 0, DATW'($urandom));
    chk("byp_data_noce", int'(data_o), int'(din));
    chk("byp_valid", int'(valid_o), 1); tick();
    ramp++; drive(0, 1, 0, 0, 0, pk(ramp));
    chk("byp_data_ce", int'(data_o), int'(din)); tick();

    ramp++; drive(0, 1, 1, 0, 4, pk(ramp)); tick();
    ramp++; drive(0, 1, 0, 1, 0, pk(ramp)); tick();
    for (int i = 0; i < 4; i++) begin
      ramp++; drive(0, 1, 0, 0, 0, pk(ramp));
      chk("flush_invalid", int'(valid_o), 0); tick();
    end
    ramp++; drive(0, 1, 0, 0, 0, pk(ramp));
    chk("flush_refill", int'(valid_o), 1);
    chk("flush_data", int'(data_o), int'(pk(ramp - 4))); tick();

    drive(1, 1, 1, 0, 7, pk(ramp)); tick();
    drive(0, 0, 0, 0, 0, pk(0));
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_delay", int'(delay_o), INIT);
    chk("rst_err", int'(delay_err_o), 0); tick();

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
            int'($urandom_range(0, 15)), DATW'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
